// File: rtl/lift_pkg.sv
// Shared definitions for the lift controller: floor sizing, door encoding,
// dispatcher FSM states and the round-robin floor picker.
package lift_pkg;

  localparam int NUM_FLOORS = 8;
  localparam int FLOOR_W    = 3;

  localparam logic [1:0] DOOR_CLOSED = 2'b00;
  localparam logic [1:0] DOOR_OPEN   = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    PRESENT,
    FREEZE
  } disp_state_t;

  typedef struct packed {
    logic               found;
    logic [FLOOR_W-1:0] floor;
  } rr_pick_t;

  // First set bit of req at or above start, wrapping from the top floor to 0.
  // Scanning from the far end lets the nearest hit overwrite the others.
  function automatic rr_pick_t rr_pick(input logic [NUM_FLOORS-1:0] req,
                                       input logic [FLOOR_W-1:0]    start);
    rr_pick_t           pick;
    logic [FLOOR_W-1:0] idx;
    pick = '0;
    for (int k = NUM_FLOORS - 1; k >= 0; k--) begin
      idx = start + FLOOR_W'(k);
      if (req[idx]) begin
        pick.found = 1'b1;
        pick.floor = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/call_dispatcher_if.sv
// Bundle of lift-side signals seen by the call dispatcher.
// master = lift environment (buttons, core status); slave = dispatcher.
interface call_dispatcher_if;
  import lift_pkg::*;

  logic [NUM_FLOORS-1:0] buttons;
  logic                  emergency_stop;
  logic [FLOOR_W-1:0]    current_floor;
  logic [1:0]            door;
  logic [FLOOR_W-1:0]    req_floor;
  logic                  req_valid;
  logic [NUM_FLOORS-1:0] pending;
  logic [NUM_FLOORS-1:0] lamp;

  modport master (
    output buttons, emergency_stop, current_floor, door,
    input  req_floor, req_valid, pending, lamp
  );

  modport slave (
    input  buttons, emergency_stop, current_floor, door,
    output req_floor, req_valid, pending, lamp
  );

endinterface

// File: rtl/call_dispatcher_debouncer.sv
// One call button: 2-flop synchroniser, stability counter and a one-cycle
// pulse on each rising edge of the debounced level.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       level_q, level_d;
  logic       press_q, press_d;
  logic [3:0] cnt_q,   cnt_d;

  // Count consecutive samples that disagree with the accepted level; flip on the Nth.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == 4'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // Synchroniser, debounce state and press pulse registers.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/call_dispatcher.sv
// Call dispatcher: debounces floor buttons, keeps the pending-call register
// and offers pending calls to the lift core one at a time, round-robin.
module call_dispatcher
  import lift_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 2
) (
  input  logic              clk,
  input  logic              reset,
  call_dispatcher_if.slave  bus
);

  disp_state_t           state_q,     state_d;
  logic [FLOOR_W-1:0]    req_floor_q, req_floor_d;
  logic [FLOOR_W-1:0]    ptr_q,       ptr_d;
  logic [3:0]            hold_q,      hold_d;
  logic [NUM_FLOORS-1:0] pending_q,   pending_d;
  logic [NUM_FLOORS-1:0] press;
  logic [NUM_FLOORS-1:0] served;
  rr_pick_t              pick;

  for (genvar f = 0; f < NUM_FLOORS; f++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk     (clk),
      .reset   (reset),
      .btn_raw (bus.buttons[f]),
      .press   (press[f])
    );
  end

  // Pending calls: presses set, service clears, and clear wins a tie.
  always_comb begin
    served    = (bus.door == DOOR_OPEN) ? (NUM_FLOORS'(1) << bus.current_floor) : '0;
    pending_d = (pending_q | press) & ~served;
  end

  // Dispatcher next state: emergency overrides everything, else round-robin issue.
  always_comb begin
    state_d     = state_q;
    req_floor_d = req_floor_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    pick        = rr_pick(pending_q, ptr_q);
    if (bus.emergency_stop) begin
      state_d = FREEZE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|pending_q) state_d = SELECT;
        end
        SELECT: begin
          if (pick.found) begin
            req_floor_d = pick.floor;
            hold_d      = 4'(HOLD_CYCLES);
            state_d     = PRESENT;
          end else begin
            state_d = IDLE;
          end
        end
        PRESENT: begin
          hold_d = hold_q - 4'd1;
          if (hold_q == 4'd1) begin
            ptr_d   = req_floor_q + 3'd1;
            state_d = SELECT;
          end
          // A call served mid-presentation is withdrawn on the very next cycle.
          if (!pending_d[req_floor_q]) state_d = SELECT;
        end
        FREEZE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Dispatcher and pending-call registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      req_floor_q <= '0;
      ptr_q       <= '0;
      hold_q      <= '0;
      pending_q   <= '0;
    end else begin
      state_q     <= state_d;
      req_floor_q <= req_floor_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      pending_q   <= pending_d;
    end
  end

  assign bus.req_valid = (state_q == PRESENT);
  assign bus.req_floor = req_floor_q;
  assign bus.pending   = pending_q;
  assign bus.lamp      = pending_q;

endmodule

// File: tb/tb_call_dispatcher.sv
// Self-checking bench for call_dispatcher: directed scenarios with literal
// expectations, then randomized traffic compared every cycle to a model.
module tb_call_dispatcher;
  import lift_pkg::*;

  localparam int DEB  = 4;
  localparam int HOLD = 2;

  logic clk = 1'b0;
  logic reset;
  call_dispatcher_if bus();

  call_dispatcher #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (HOLD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;
  int estop_left;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_present(input logic [2:0] f, input int budget, input string name);
    int n = 0;
    while (!(bus.req_valid === 1'b1 && bus.req_floor === f) && n < budget) begin
      step(1);
      n++;
    end
    check(name, (bus.req_valid === 1'b1 && bus.req_floor === f), 1'b1);
  endtask

  task automatic wait_valid(input logic v, input int budget, input string name);
    int n = 0;
    while (bus.req_valid !== v && n < budget) begin
      step(1);
      n++;
    end
    check(name, bus.req_valid, v);
  endtask

  // ---------------- behavioural reference model ----------------
  // Inputs: raw buttons reach the debouncer two edges late; a level flips once
  // the last DEB synchronised samples all disagree with it.
  // Dispatch: m_left = remaining presentation cycles (0 = not presenting),
  // m_select = a one-cycle choosing gap is in progress, m_frozen = emergency.
  bit [7:0]  m_pending, m_press, m_level, m_r1, m_r2, m_served, m_next;
  bit [14:0] m_hist [8];
  bit [2:0]  m_req_floor;
  int        m_ptr, m_left;
  bit        m_select, m_frozen, m_found, m_flip;

  always @(posedge clk) begin
    if (reset) begin
      m_pending = '0; m_press = '0; m_level = '0; m_r1 = '0; m_r2 = '0;
      for (int i = 0; i < 8; i++) m_hist[i] = '0;
      m_req_floor = '0; m_ptr = 0; m_left = 0; m_select = 0; m_frozen = 0;
    end else begin
      m_served = (bus.door == 2'b01) ? (8'd1 << bus.current_floor) : 8'd0;
      m_next   = (m_pending | m_press) & ~m_served;

      if (bus.emergency_stop) begin
        m_frozen = 1; m_select = 0; m_left = 0;
      end else if (m_frozen) begin
        m_frozen = 0;
      end else if (m_select) begin
        m_select = 0;
        m_found  = 0;
        for (int k = 0; k < 8; k++) begin
          if (!m_found && m_pending[(m_ptr + k) % 8]) begin
            m_found     = 1;
            m_req_floor = 3'((m_ptr + k) % 8);
          end
        end
        if (m_found) m_left = HOLD;
      end else if (m_left > 0) begin
        if (m_left == 1) m_ptr = (int'(m_req_floor) + 1) % 8;
        if (m_left == 1 || !m_next[m_req_floor]) begin
          m_left = 0; m_select = 1;
        end else begin
          m_left--;
        end
      end else if (m_pending != 0) begin
        m_select = 1;
      end

      for (int i = 0; i < 8; i++) begin
        m_hist[i] = {m_hist[i][13:0], m_r2[i]};
        m_flip = 1;
        for (int j = 0; j < DEB; j++) if (m_hist[i][j] == m_level[i]) m_flip = 0;
        m_press[i] = m_flip & ~m_level[i];
        if (m_flip) m_level[i] = ~m_level[i];
      end
      m_r2 = m_r1;
      m_r1 = bus.buttons;
      m_pending = m_next;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_req_valid", bus.req_valid, (m_left > 0));
      check("model_req_floor", bus.req_floor, m_req_floor);
      check("model_pending",   bus.pending,   m_pending);
      check("model_lamp",      bus.lamp,      m_pending);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    bus.buttons = '0; bus.emergency_stop = 1'b0;
    bus.current_floor = '0; bus.door = DOOR_CLOSED;
    reset = 1'b1;
    step(2);
    cmp_en = 1'b1;
    check("reset_req_valid", bus.req_valid, 0);
    check("reset_req_floor", bus.req_floor, 0);
    check("reset_pending",   bus.pending,   0);
    check("reset_lamp",      bus.lamp,      0);

    // Held press of floor 5: pending at edge 7, presented at edges 9-10, period 3.
    reset = 1'b0;
    bus.buttons = 8'h20;
    step(6);  check("latency_early",  bus.pending, 8'h00);
    step(1);  check("latency_7",      bus.pending, 8'h20);
    step(1);  check("edge8_valid",    bus.req_valid, 0);
    step(1);  check("edge9_valid",    bus.req_valid, 1);
              check("edge9_floor",    bus.req_floor, 5);
    step(1);  check("edge10_valid",   bus.req_valid, 1);
    step(1);  check("edge11_gap",     bus.req_valid, 0);
    step(1);  check("edge12_valid",   bus.req_valid, 1);
    step(3);  check("edge15_valid",   bus.req_valid, 1);
    bus.current_floor = 3'd5; bus.door = DOOR_OPEN;
    step(1);  check("serve5_pending", bus.pending, 8'h00);
              check("serve5_valid",   bus.req_valid, 0);
    bus.buttons = '0; bus.door = DOOR_CLOSED;
    step(10); check("idle_after_5",   bus.req_valid, 0);

    // Two-cycle glitch on floor 3 must be filtered out.
    bus.buttons = 8'h08;
    step(2);
    bus.buttons = 8'h00;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      seen |= (|bus.pending) | bus.req_valid;
    end
    check("glitch_filtered", seen, 0);

    // Floor 4 expires once (ptr=5), then 1 and 6 are pressed under emergency.
    bus.buttons = 8'h10;
    wait_present(3'd4, 30, "present4");
    wait_valid(1'b0, 10, "expire4");
    bus.emergency_stop = 1'b1;
    bus.buttons = 8'h52;
    step(9);  check("freeze_pending", bus.pending, 8'h52);
              check("freeze_valid",   bus.req_valid, 0);
    bus.emergency_stop = 1'b0;
    step(1);  check("rel_idle",       bus.req_valid, 0);
    step(1);  check("rel_select",     bus.req_valid, 0);
    step(1);  check("rr_first",       bus.req_floor, 6);
              check("rr_first_v",     bus.req_valid, 1);
    step(1);  check("rr_first_hold",  bus.req_valid, 1);
    step(1);  check("rr_gap1",        bus.req_valid, 0);
    step(1);  check("rr_second",      bus.req_floor, 1);
              check("rr_second_v",    bus.req_valid, 1);
    step(1);  check("rr_second_hold", bus.req_valid, 1);
    step(1);  check("rr_gap2",        bus.req_valid, 0);
    step(1);  check("rr_third",       bus.req_floor, 4);
              check("rr_third_v",     bus.req_valid, 1);

    // Serve floor 4 on its first presented cycle.
    bus.current_floor = 3'd4; bus.door = DOOR_OPEN;
    step(1);  check("serve4_pending", bus.pending, 8'h42);
              check("serve4_drop",    bus.req_valid, 0);
    bus.door = DOOR_CLOSED;
    bus.buttons = 8'h00;
    step(1);  check("rr_fourth",      bus.req_floor, 6);
              check("rr_fourth_v",    bus.req_valid, 1);

    // Clear remaining calls, then emergency while presenting floor 2.
    bus.current_floor = 3'd6; bus.door = DOOR_OPEN;
    step(1);
    bus.current_floor = 3'd1;
    step(1);
    bus.door = DOOR_CLOSED;
    step(1);  check("all_served",     bus.pending, 8'h00);
    step(10);
    bus.buttons = 8'h04;
    wait_present(3'd2, 30, "present2");
    bus.emergency_stop = 1'b1;
    step(1);  check("estop_drop",     bus.req_valid, 0);
    bus.buttons = 8'h84;
    step(9);  check("estop_press7",   bus.pending, 8'h84);
              check("estop_frozen",   bus.req_valid, 0);
    bus.buttons = 8'h00;
    bus.emergency_stop = 1'b0;
    step(1);  check("rel2_idle",      bus.req_valid, 0);
    step(1);  check("rel2_select",    bus.req_valid, 0);
    step(1);  check("rel2_valid",     bus.req_valid, 1);
              check("rel2_floor",     (bus.req_floor == 3'd2 || bus.req_floor == 3'd7), 1'b1);

    // Press of floor 0 while being served at floor 0 never latches.
    bus.current_floor = 3'd0; bus.door = DOOR_OPEN;
    bus.buttons = 8'h01;
    step(12); check("press_served0",  bus.pending[0], 0);
    bus.buttons = 8'h00; bus.door = DOOR_CLOSED;

    // Reset during a presentation.
    wait_valid(1'b1, 30, "present_before_reset");
    reset = 1'b1;
    step(1);
    check("rst_mid_valid",   bus.req_valid, 0);
    check("rst_mid_floor",   bus.req_floor, 0);
    check("rst_mid_pending", bus.pending,   0);
    check("rst_mid_lamp",    bus.lamp,      0);
    reset = 1'b0;

    // Randomized traffic checked by the model process.
    estop_left = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 15) == 0) bus.buttons[b] = ~bus.buttons[b];
      if ($urandom_range(0, 7) == 0) bus.current_floor = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0)      bus.door = DOOR_OPEN;
      else if ($urandom_range(0, 9) == 0) bus.door = 2'b10;
      else                                bus.door = DOOR_CLOSED;
      if (estop_left > 0) estop_left--;
      else if ($urandom_range(0, 99) == 0) estop_left = $urandom_range(1, 8);
      bus.emergency_stop = (estop_left > 0);
      reset = ($urandom_range(0, 499) == 0);
      step(1);
    end
    reset = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/call_dispatcher.md
# call_dispatcher

Upstream request stage for the 8-floor lift controller. It synchronises and debounces the raw floor-call buttons, keeps a pending-call register with lamp outputs, and presents pending calls one at a time, round-robin, on `req_floor`/`req_valid` to the lift core. A call is retired when the lift stands at that floor with the door open. Request issue is frozen while emergency stop is active.

## Interface
- `NUM_FLOORS`, 8: number of floors, fixed at 8 for this core.
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronised samples needed to accept a level change. Range 1..15.
- `HOLD_CYCLES`, 2: cycles each request is held valid. Range 1..15.

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `buttons`  in  8  raw call buttons, asynchronous, bit f = floor f
- `emergency_stop`  in  1  freezes request issue while high
- `current_floor`  in  3  floor reported by the lift core
- `door`  in  2  door state from the lift core; `DOOR_OPEN` = 2'b01
- `req_floor`  out  3  floor being requested
- `req_valid`  out  1  `req_floor` is a live request
- `pending`  out  8  outstanding calls, bit f = floor f
- `lamp`  out  8  call-acknowledge lamps, equal to `pending`

## Operation
- Input path, per bit:
  - 2-flop synchroniser.
  - Debouncer counter: the debounced level changes only after `DEBOUNCE_CYCLES` consecutive samples differ from it.
  - A press is the rising edge of the debounced level.
- Pending register, per bit f:
  - Set on a press of f.
  - Cleared when `current_floor==f && door==DOOR_OPEN` ("served").
  - If a press and service of f occur in the same cycle, clear wins; the call is not latched.
  - `emergency_stop` does not block setting or clearing.
- FSM states:
  - IDLE: `req_valid=0`. Go to SELECT when `pending != 0`.
  - SELECT: 1 cycle. Choose the first set bit searching upward from `ptr`, wrapping 7→0. Load that floor into `req_floor`, load the hold counter with `HOLD_CYCLES`, go to PRESENT. If `pending == 0`, go to IDLE.
  - PRESENT: `req_valid=1`. Decrement the hold counter each cycle. At expiry, set `ptr = req_floor+1` (mod 8) and go to SELECT. If `pending[req_floor]` clears, drop `req_valid` the next cycle and go to SELECT.
  - FREEZE: entered from any state on `emergency_stop=1`. `req_valid=0`. Pending bits are retained. Exit to IDLE on the first cycle `emergency_stop=0`.
- `req_floor` holds its last value when `req_valid=0`.
- `lamp` is a direct copy of `pending`.

## Timing
- Reset values:
  - `req_floor=0`, `req_valid=0`, `pending=0`, `lamp=0`.
  - `ptr=0`, FSM in IDLE.
  - Synchroniser and debounced levels 0, debounce counters 0.
- Reset mid-operation: all pending calls are discarded. Buttons still held after reset re-register only after a fresh rising edge of the debounced level.
- Latency from raw press (held stable) to pending visible: 2 (sync) + `DEBOUNCE_CYCLES` + 1 (register) cycles, i.e. 7 with defaults.
- Pending to `req_valid` high, from IDLE: 2 cycles (IDLE→SELECT, SELECT→PRESENT).
- `req_valid` stays high for exactly `HOLD_CYCLES` cycles unless the call is served or emergency asserts first.
- Back-to-back requests have one `req_valid=0` cycle (SELECT) between them.
- Service clear takes effect one cycle after the qualifying `current_floor`/`door` sample.
- `emergency_stop` takes effect the next cycle.
- Glitches shorter than `DEBOUNCE_CYCLES` produce no press.

## Structure
- Shared package `lift_pkg`:
  - `NUM_FLOORS`, `FLOOR_W=3`.
  - Door encoding constants `DOOR_OPEN=2'b01`, `DOOR_CLOSED=2'b00`.
  - FSM enum `disp_state_t` {IDLE, SELECT, PRESENT, FREEZE}.
- Sub-module `button_debouncer` (one bit: synchroniser, counter, rising-edge pulse), instantiated 8× via generate.
- Round-robin search and FSM live in the top module.

## Test plan
- Reset, then hold `buttons[5]` stable high: `pending=8'h20` at cycle 7. `req_valid=1` with `req_floor=5` at cycles 9–10. Re-presented every 3 cycles until served.
- 2-cycle glitch on `buttons[3]`: `pending` stays 0 and `req_valid` never asserts.
- Pending {1,4,6} with `ptr=5`: presentation order 6, 1, 4, 6… with one SELECT gap between requests.
- Floor 4 presented; `current_floor=4`, `door=01` on the first PRESENT cycle: `pending[4]` clears and `req_valid` drops the following cycle. Next pending floor is then selected.
- `emergency_stop` high while presenting 2: `req_valid=0` next cycle. A press of 7 during emergency sets `pending[7]`. After release: IDLE, SELECT, then floor 7 or 2 presented per `ptr`.
- Press of floor 0 while `current_floor=0` and door open: `pending[0]` never sets. Reset during PRESENT: all outputs 0 the next cycle.
